// File: rtl/fpu_pkg.sv
// Shared FPU opcodes, sequencer states and owner id type
// for the dual-core FPU sharing controller.
package fpu_pkg;

  localparam logic [4:0] FADD_S   = 5'b00000;
  localparam logic [4:0] FSUB_S   = 5'b00001;
  localparam logic [4:0] FMUL_S   = 5'b00010;
  localparam logic [4:0] FDIV_S   = 5'b00011;
  localparam logic [4:0] FSQRT_S  = 5'b00100;
  localparam logic [4:0] FMADD_S  = 5'b10110;
  localparam logic [4:0] FMSUB_S  = 5'b10111;
  localparam logic [4:0] FNMSUB_S = 5'b11000;
  localparam logic [4:0] FNMADD_S = 5'b11001;

  localparam int OWN_W = 1;

  typedef logic [OWN_W-1:0] own_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DIV_ARM,
    ST_DIV_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/fpu_rr_arb2.sv
// Two-way round-robin arbiter; flushing cores are masked out
// and the last-grant pointer only moves on accept.
module fpu_rr_arb2
  import fpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       accept,
  output logic       gnt_vld,
  output own_t       gnt_id
);

  logic [1:0] act;
  own_t       last_q;

  assign act     = req & ~mask;
  assign gnt_vld = |act;

  always_comb begin
    gnt_id = own_t'(act[1]);
    if (act == 2'b11) gnt_id = ~last_q;
  end

  // Reset value 1 makes core 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= own_t'(1);
    end else if (accept && gnt_vld) begin
      last_q <= gnt_id;
    end
  end

endmodule

// File: rtl/fpu_share_ctrl.sv
// Sequencer letting two cores share one FPU: arbitrates,
// registers operands, waits out divides, returns results.
module fpu_share_ctrl
  import fpu_pkg::*;
#(
  parameter int DIV_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic        in_Clk,
  input  logic        in_Rst_N,
  input  logic        in_req0,
  input  logic        in_req1,
  input  logic [4:0]  in_op0,
  input  logic [4:0]  in_op1,
  input  logic [31:0] in_a0,
  input  logic [31:0] in_b0,
  input  logic [31:0] in_a1,
  input  logic [31:0] in_b1,
  input  logic        in_flush0,
  input  logic        in_flush1,
  output logic        out_done0,
  output logic        out_done1,
  output logic [31:0] out_result,
  output logic        out_timeout,
  output logic        out_busy,
  output logic        out_fpu_start,
  output logic [4:0]  out_fpu_op,
  output logic [31:0] out_fpu_a,
  output logic [31:0] out_fpu_b,
  input  logic [31:0] in_fpu_data,
  input  logic        in_fpu_stall
);

  state_e      state_q, state_d;
  own_t        own_q, gnt_id;
  logic        gnt_vld, accept, cancel_q;
  logic        cap, tmo_set, flush_own, resp_ok;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [4:0]  sel_op;
  logic [31:0] sel_a, sel_b;

  fpu_rr_arb2 u_arb (
    .clk     (in_Clk),
    .rst_n   (in_Rst_N),
    .req     ({in_req1, in_req0}),
    .mask    ({in_flush1, in_flush0}),
    .accept  (state_q == ST_IDLE),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  assign accept    = (state_q == ST_IDLE) && gnt_vld;
  assign sel_op    = gnt_id[0] ? in_op1 : in_op0;
  assign sel_a     = gnt_id[0] ? in_a1  : in_a0;
  assign sel_b     = gnt_id[0] ? in_b1  : in_b0;
  assign flush_own = own_q[0] ? in_flush1 : in_flush0;
  assign cnt_nx    = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    tmo_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          state_d = (sel_op == FDIV_S) ? ST_DIV_ARM : ST_EXEC;
        end
      end
      ST_EXEC: begin
        cap     = 1'b1;
        state_d = ST_RESP;
      end
      ST_DIV_ARM: state_d = ST_DIV_WAIT;
      ST_DIV_WAIT: begin
        if (!in_fpu_stall) begin
          cap     = 1'b1;
          state_d = ST_RESP;
        end else if (cnt_nx == CNT_W'(DIV_TIMEOUT)) begin
          cap     = 1'b1;
          tmo_set = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Start is registered so the FPU sees it with the latched operands.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      state_q       <= ST_IDLE;
      own_q         <= '0;
      cancel_q      <= 1'b0;
      cnt_q         <= '0;
      out_fpu_op    <= '0;
      out_fpu_a     <= '0;
      out_fpu_b     <= '0;
      out_result    <= '0;
      out_timeout   <= 1'b0;
      out_fpu_start <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_fpu_start <= accept && (sel_op == FDIV_S);
      if (accept) begin
        own_q      <= gnt_id;
        out_fpu_op <= sel_op;
        out_fpu_a  <= sel_a;
        out_fpu_b  <= sel_b;
        cancel_q   <= 1'b0;
        cnt_q      <= '0;
      end else if (state_q != ST_IDLE && flush_own) begin
        cancel_q <= 1'b1;
      end
      if (state_q == ST_DIV_WAIT) cnt_q <= cnt_nx;
      if (cap) out_result <= in_fpu_data;
      if (tmo_set) out_timeout <= 1'b1;
    end
  end

  assign resp_ok   = (state_q == ST_RESP) && !cancel_q && !flush_own;
  assign out_done0 = resp_ok && !own_q[0];
  assign out_done1 = resp_ok && own_q[0];
  assign out_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpu_share_ctrl.sv
// Directed self-checking bench for fpu_share_ctrl with a
// table-driven FPU result model and a counted stall model.
module tb_fpu_share_ctrl;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 0, req1 = 0, flush0 = 0, flush1 = 0;
  logic [4:0]  op0 = '0, op1 = '0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        done0, done1, tmo, busy, start;
  logic [31:0] result, fpu_a, fpu_b, fpu_data;
  logic [4:0]  fpu_op;
  logic        fpu_stall;

  int n_cmp = 0, n_err = 0;
  int n_done0 = 0, n_done1 = 0, n_start = 0;
  int stall_cnt = 0, stall_len = 0;
  bit stall_forever = 0;

  always #5 clk = ~clk;

  fpu_share_ctrl dut (
    .in_Clk(clk), .in_Rst_N(rst_n),
    .in_req0(req0), .in_req1(req1),
    .in_op0(op0), .in_op1(op1),
    .in_a0(a0), .in_b0(b0), .in_a1(a1), .in_b1(b1),
    .in_flush0(flush0), .in_flush1(flush1),
    .out_done0(done0), .out_done1(done1),
    .out_result(result), .out_timeout(tmo),
    .out_busy(busy), .out_fpu_start(start),
    .out_fpu_op(fpu_op), .out_fpu_a(fpu_a), .out_fpu_b(fpu_b),
    .in_fpu_data(fpu_data), .in_fpu_stall(fpu_stall)
  );

  function automatic logic [31:0] fmodel(input logic [4:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    if (op == FADD_S && a == 32'h3F800000 && b == 32'h40000000)
      return 32'h40400000;
    if (op == FADD_S && a == 32'h40000000 && b == 32'h40000000)
      return 32'h40800000;
    if (op == FSUB_S && a == 32'h40400000 && b == 32'h3F800000)
      return 32'h40000000;
    if (op == FMUL_S && a == 32'h40000000 && b == 32'h40400000)
      return 32'h40C00000;
    if (op == FDIV_S && a == 32'h40C00000 && b == 32'h40000000)
      return 32'h40400000;
    if (op == FDIV_S && a == 32'h41000000 && b == 32'h40000000)
      return 32'h40800000;
    if (op == FDIV_S && a == 32'h41200000 && b == 32'h40000000)
      return 32'h40A00000;
    return 32'hBAD0BAD0;
  endfunction

  always_comb fpu_data = fmodel(fpu_op, fpu_a, fpu_b);
  assign fpu_stall = stall_forever || (stall_cnt != 0);

  always @(posedge clk) begin
    if (start) stall_cnt <= stall_len;
    else if (stall_cnt > 0) stall_cnt <= stall_cnt - 1;
  end

  always @(negedge clk) begin
    if (done0) n_done0++;
    if (done1) n_done1++;
    if (start) n_start++;
  end

  task automatic drive(input int core, input logic r,
                       input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (core == 0) begin req0 = r; op0 = op; a0 = a; b0 = b; end
    else begin req1 = r; op1 = op; a1 = a; b1 = b; end
  endtask

  task automatic wait_done(input logic [1:0] mask, input int budget,
                           output int who, output int cycles,
                           output bit busy_all);
    who = -1; cycles = 0; busy_all = 1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      busy_all &= busy;
      if (mask[0] && done0) begin who = 0; cycles = i; return; end
      if (mask[1] && done1) begin who = 1; cycles = i; return; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({busy, done0, done1, start, tmo} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags: got %b want 00000",
                        {busy, done0, done1, start, tmo});
    end
    n_cmp++; if (result !== 32'h0) begin
      n_err++; $display("FAIL reset_result: got %h want 0", result);
    end
    n_cmp++; if ({fpu_op, fpu_a, fpu_b} !== 69'h0) begin
      n_err++; $display("FAIL reset_fpu_regs: got %h want 0",
                        {fpu_op, fpu_a, fpu_b});
    end
  endtask

  task automatic test_tie(input int first);
    int who, cyc, d1; bit ba;
    logic [31:0] exp0, exp1;
    exp0 = 32'h40800000; exp1 = 32'h40000000;
    @(negedge clk);
    drive(0, 1, FADD_S, 32'h40000000, 32'h40000000);
    drive(1, 1, FSUB_S, 32'h40400000, 32'h3F800000);
    wait_done(2'b11, 10, who, cyc, ba);
    n_cmp++; if (who !== first || cyc !== 2) begin
      n_err++; $display("FAIL tie_first: got core %0d cyc %0d want core %0d cyc 2",
                        who, cyc, first);
    end
    n_cmp++; if (result !== (first == 0 ? exp0 : exp1)) begin
      n_err++; $display("FAIL tie_first_result: got %h", result);
    end
    drive(first, 0, FADD_S, 32'h0, 32'h0);
    d1 = 1 - first;
    wait_done(2'b11, 10, who, cyc, ba);
    n_cmp++; if (who !== d1 || cyc !== 3) begin
      n_err++; $display("FAIL tie_second: got core %0d cyc %0d want core %0d cyc 3",
                        who, cyc, d1);
    end
    n_cmp++; if (result !== (d1 == 0 ? exp0 : exp1)) begin
      n_err++; $display("FAIL tie_second_result: got %h", result);
    end
    drive(d1, 0, FADD_S, 32'h0, 32'h0);
  endtask

  task automatic test_single_fadd();
    int who, cyc, d1; bit ba;
    @(negedge clk);
    d1 = n_done1;
    drive(0, 1, FADD_S, 32'h3F800000, 32'h40000000);
    wait_done(2'b01, 10, who, cyc, ba);
    n_cmp++; if (who !== 0 || cyc !== 2) begin
      n_err++; $display("FAIL fadd_latency: got core %0d cyc %0d want core 0 cyc 2",
                        who, cyc);
    end
    n_cmp++; if (result !== 32'h40400000) begin
      n_err++; $display("FAIL fadd_result: got %h want 40400000", result);
    end
    n_cmp++; if (n_done1 - d1 !== 0) begin
      n_err++; $display("FAIL fadd_no_done1: got %0d pulses want 0", n_done1 - d1);
    end
    drive(0, 0, FADD_S, 32'h0, 32'h0);
  endtask

  task automatic test_div();
    int who, cyc, s0; bit ba;
    @(negedge clk);
    s0 = n_start; stall_len = 10;
    drive(1, 1, FDIV_S, 32'h40C00000, 32'h40000000);
    wait_done(2'b10, 40, who, cyc, ba);
    n_cmp++; if (who !== 1 || cyc !== 13) begin
      n_err++; $display("FAIL div_latency: got core %0d cyc %0d want core 1 cyc 13",
                        who, cyc);
    end
    n_cmp++; if (result !== 32'h40400000) begin
      n_err++; $display("FAIL div_result: got %h want 40400000", result);
    end
    n_cmp++; if (n_start - s0 !== 1) begin
      n_err++; $display("FAIL div_start_count: got %0d want 1", n_start - s0);
    end
    n_cmp++; if (ba !== 1'b1) begin
      n_err++; $display("FAIL div_busy: got %b want 1", ba);
    end
    n_cmp++; if (tmo !== 1'b0) begin
      n_err++; $display("FAIL div_timeout: got %b want 0", tmo);
    end
    drive(1, 0, FADD_S, 32'h0, 32'h0);
  endtask

  task automatic test_timeout();
    int who, cyc; bit ba;
    @(negedge clk);
    stall_forever = 1;
    drive(0, 1, FDIV_S, 32'h41000000, 32'h40000000);
    wait_done(2'b01, 100, who, cyc, ba);
    n_cmp++; if (who !== 0 || cyc !== 66) begin
      n_err++; $display("FAIL tmo_latency: got core %0d cyc %0d want core 0 cyc 66",
                        who, cyc);
    end
    n_cmp++; if (tmo !== 1'b1 || result !== 32'h40800000) begin
      n_err++; $display("FAIL tmo_flag_result: got %b %h want 1 40800000",
                        tmo, result);
    end
    drive(0, 0, FADD_S, 32'h0, 32'h0);
    stall_forever = 0;
    repeat (2) @(negedge clk);
    n_cmp++; if (tmo !== 1'b1) begin
      n_err++; $display("FAIL tmo_sticky: got %b want 1", tmo);
    end
  endtask

  task automatic test_flush();
    int who, cyc, d0, d1, idle_wait; bit ba;
    @(negedge clk);
    d0 = n_done0; d1 = n_done1; stall_len = 20;
    drive(0, 1, FDIV_S, 32'h41200000, 32'h40000000);
    repeat (4) @(negedge clk);
    flush0 = 1;
    drive(0, 0, FADD_S, 32'h0, 32'h0);
    drive(1, 1, FMUL_S, 32'h40000000, 32'h40400000);
    @(negedge clk);
    flush0 = 0;
    idle_wait = 1;
    for (int i = 0; i < 60 && busy; i++) begin
      @(negedge clk);
      idle_wait++;
    end
    n_cmp++; if (idle_wait !== 20) begin
      n_err++; $display("FAIL flush_drain: got %0d cycles want 20", idle_wait);
    end
    n_cmp++; if (result !== 32'h40A00000) begin
      n_err++; $display("FAIL flush_result: got %h want 40A00000", result);
    end
    n_cmp++; if (n_done0 - d0 !== 0 || n_done1 - d1 !== 0) begin
      n_err++; $display("FAIL flush_no_done: got %0d/%0d want 0/0",
                        n_done0 - d0, n_done1 - d1);
    end
    wait_done(2'b10, 10, who, cyc, ba);
    n_cmp++; if (who !== 1 || cyc !== 2) begin
      n_err++; $display("FAIL flush_other: got core %0d cyc %0d want core 1 cyc 2",
                        who, cyc);
    end
    n_cmp++; if (result !== 32'h40C00000 || n_done0 - d0 !== 0) begin
      n_err++; $display("FAIL flush_other_result: got %h done0 %0d",
                        result, n_done0 - d0);
    end
    drive(1, 0, FADD_S, 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid();
    int who, cyc; bit ba;
    @(negedge clk);
    drive(0, 1, FMUL_S, 32'h40000000, 32'h40400000);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || fpu_op !== FMUL_S) begin
      n_err++; $display("FAIL mid_exec: got busy %b op %h", busy, fpu_op);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done0, done1, start, tmo} !== 5'b0) begin
      n_err++; $display("FAIL mid_rst_flags: got %b want 00000",
                        {busy, done0, done1, start, tmo});
    end
    n_cmp++; if ({result, fpu_op, fpu_a, fpu_b} !== 101'h0) begin
      n_err++; $display("FAIL mid_rst_regs: got %h want 0",
                        {result, fpu_op, fpu_a, fpu_b});
    end
    drive(0, 0, FADD_S, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(0, 1, FMUL_S, 32'h40000000, 32'h40400000);
    wait_done(2'b01, 10, who, cyc, ba);
    n_cmp++; if (who !== 0 || cyc !== 2 || result !== 32'h40C00000) begin
      n_err++; $display("FAIL post_rst_fmul: got core %0d cyc %0d res %h",
                        who, cyc, result);
    end
    drive(0, 0, FADD_S, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_tie(0);
    test_single_fadd();
    test_tie(1);
    test_div();
    test_timeout();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
